// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the generated CSR register cells:
//   - csr_mode_e        : per-bit access mode
//   - byte_to_bit_mask  : expands byte enables into a per-bit mask
//   - mask_check        : true when every bit belongs to exactly one mode mask
//   - mode_of_bit       : derives the access mode of one bit from the masks
// Functions work on a fixed maximum width so one copy serves every register
// width up to CSR_MAX_W bits.
// -----------------------------------------------------------------------------
package csr_pkg;

    localparam int CSR_MAX_W  = 256;
    localparam int CSR_MAX_BE = CSR_MAX_W / 8;

    typedef enum logic [2:0] {
        RW,
        RO,
        W1C,
        W1S,
        W0C,
        RC,
        RS
    } csr_mode_e;

    function automatic logic [CSR_MAX_W-1:0] byte_to_bit_mask(
        input logic [CSR_MAX_BE-1:0] be
    );
        logic [CSR_MAX_W-1:0] mask;
        for (int i = 0; i < CSR_MAX_W; i++) begin
            mask[i] = be[i / 8];
        end
        return mask;
    endfunction

    function automatic bit mask_check(
        input int                   width,
        input logic [CSR_MAX_W-1:0] rw,
        input logic [CSR_MAX_W-1:0] ro,
        input logic [CSR_MAX_W-1:0] w1c,
        input logic [CSR_MAX_W-1:0] w1s,
        input logic [CSR_MAX_W-1:0] w0c,
        input logic [CSR_MAX_W-1:0] rc,
        input logic [CSR_MAX_W-1:0] rs
    );
        int hits;
        if (width <= 0 || width > CSR_MAX_W || (width % 8) != 0) begin
            return 1'b0;
        end
        for (int i = 0; i < width; i++) begin
            hits = int'(rw[i]) + int'(ro[i]) + int'(w1c[i]) + int'(w1s[i])
                 + int'(w0c[i]) + int'(rc[i]) + int'(rs[i]);
            if (hits != 1) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    // RW is the fall-through mode; mask_check guarantees a bit that is in no
    // other mask is in RW_MASK.
    function automatic csr_mode_e mode_of_bit(
        input int                   idx,
        input logic [CSR_MAX_W-1:0] ro,
        input logic [CSR_MAX_W-1:0] w1c,
        input logic [CSR_MAX_W-1:0] w1s,
        input logic [CSR_MAX_W-1:0] w0c,
        input logic [CSR_MAX_W-1:0] rc,
        input logic [CSR_MAX_W-1:0] rs
    );
        if (ro[idx])  return RO;
        if (w1c[idx]) return W1C;
        if (w1s[idx]) return W1S;
        if (w0c[idx]) return W0C;
        if (rc[idx])  return RC;
        if (rs[idx])  return RS;
        return RW;
    endfunction

endpackage

// File: rtl/csr_bit_cell.sv
// -----------------------------------------------------------------------------
// csr_bit_cell
// One bit of a CSR register: live flop, optional shadow flop (RW + shadow
// only) and the per-mode next-value mux.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sw            software write to this bit (wr_en & byte enable)
//   wr_bit        software write data bit
//   rd_en         software read strobe (read side effects)
//   hw_we, hw_bit hardware write enable / data for this bit
//   commit        shadow-to-live transfer (shadowed RW only)
//   live_q        current live value
//   live_next     value live_q takes at the next edge (absent reset)
//   shadow_next   value the shadow takes at the next edge; equals live_next
//                 for cells without a shadow so it never shows as pending
// -----------------------------------------------------------------------------
module csr_bit_cell
    import csr_pkg::*;
#(
    parameter csr_mode_e MODE      = RW,
    parameter logic      RST_BIT   = 1'b0,
    parameter bit        SHADOW_EN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic wr_bit,
    input  logic rd_en,
    input  logic hw_we,
    input  logic hw_bit,
    input  logic commit,
    output logic live_q,
    output logic live_next,
    output logic shadow_next
);

    logic shadow_q;
    logic shadow_wr;

    assign shadow_wr = sw ? wr_bit : shadow_q;

    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        live_next = live_q;
        case (MODE)
            RW: begin
                if (SHADOW_EN) begin
                    // Commit carries the freshly written value when a write
                    // lands in the same cycle.
                    if (commit)     live_next = shadow_wr;
                    else if (hw_we) live_next = hw_bit;
                end else begin
                    if (sw)         live_next = wr_bit;
                    else if (hw_we) live_next = hw_bit;
                end
            end
            RO:  if (hw_we) live_next = hw_bit;
            // Event bits: hardware wins so a set coinciding with a clear is
            // not lost.
            W1C: if (hw_we) live_next = hw_bit; else if (sw && wr_bit)  live_next = 1'b0;
            W1S: if (hw_we) live_next = hw_bit; else if (sw && wr_bit)  live_next = 1'b1;
            W0C: if (hw_we) live_next = hw_bit; else if (sw && !wr_bit) live_next = 1'b0;
            RC:  if (hw_we) live_next = hw_bit; else if (rd_en)         live_next = 1'b0;
            RS:  if (hw_we) live_next = hw_bit; else if (rd_en)         live_next = 1'b1;
            default: live_next = live_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) live_q <= RST_BIT;
        else     live_q <= live_next;
    end

    if (MODE == RW && SHADOW_EN) begin : g_shadow
        always_ff @(posedge clk) begin
            if (rst) shadow_q <= RST_BIT;
            else     shadow_q <= shadow_wr;
        end
        assign shadow_next = shadow_wr;
    end else begin : g_no_shadow
        assign shadow_q    = 1'b0;
        assign shadow_next = live_next;
    end

    // Inputs that only some modes consume.
    logic unused_inputs;
    assign unused_inputs = ^{commit, rd_en, wr_bit, sw, shadow_wr};

endmodule

// File: rtl/csr_reg_param.sv
// -----------------------------------------------------------------------------
// csr_reg_param
// Generic single CSR register with per-bit access modes, byte-enabled
// software writes, per-bit hardware updates, read side effects, optional
// shadow/commit double-buffering and a registered change pulse.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_en        software write strobe
//   wr_be        byte enables for the write
//   wr_data      software write data
//   rd_en        software read strobe (triggers RC/RS side effects)
//   rd_data      combinational read data = live value (pre-side-effect)
//   hw_we        per-bit hardware write enable
//   hw_data      hardware write data
//   commit       shadow-to-live transfer; ignored without shadowing
//   reg_o        live register value
//   pending_o    shadow RW bits differ from live RW bits (registered)
//   chg_o        one-cycle pulse aligned with any live change
// -----------------------------------------------------------------------------
module csr_reg_param
    import csr_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RST_VAL   = '0,
    parameter logic [DATA_W-1:0] RW_MASK   = '1,
    parameter logic [DATA_W-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0] W1C_MASK  = '0,
    parameter logic [DATA_W-1:0] W1S_MASK  = '0,
    parameter logic [DATA_W-1:0] W0C_MASK  = '0,
    parameter logic [DATA_W-1:0] RC_MASK   = '0,
    parameter logic [DATA_W-1:0] RS_MASK   = '0,
    parameter int                SHADOW_EN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [DATA_W-1:0]   hw_we,
    input  logic [DATA_W-1:0]   hw_data,
    input  logic                commit,
    output logic [DATA_W-1:0]   reg_o,
    output logic                pending_o,
    output logic                chg_o
);

    localparam logic [CSR_MAX_W-1:0] RW_X  = CSR_MAX_W'(RW_MASK);
    localparam logic [CSR_MAX_W-1:0] RO_X  = CSR_MAX_W'(RO_MASK);
    localparam logic [CSR_MAX_W-1:0] W1C_X = CSR_MAX_W'(W1C_MASK);
    localparam logic [CSR_MAX_W-1:0] W1S_X = CSR_MAX_W'(W1S_MASK);
    localparam logic [CSR_MAX_W-1:0] W0C_X = CSR_MAX_W'(W0C_MASK);
    localparam logic [CSR_MAX_W-1:0] RC_X  = CSR_MAX_W'(RC_MASK);
    localparam logic [CSR_MAX_W-1:0] RS_X  = CSR_MAX_W'(RS_MASK);

    if (!mask_check(DATA_W, RW_X, RO_X, W1C_X, W1S_X, W0C_X, RC_X, RS_X)) begin : g_bad_masks
        $error("csr_reg_param: DATA_W not a multiple of 8, or access masks overlap / leave bits uncovered");
    end

    logic [CSR_MAX_W-1:0] be_full;
    logic [DATA_W-1:0]    sw;
    logic [DATA_W-1:0]    live_q;
    logic [DATA_W-1:0]    live_next;
    logic [DATA_W-1:0]    shadow_next;
    logic                 chg_q;
    logic                 pending_q;

    assign be_full = byte_to_bit_mask(CSR_MAX_BE'(wr_be));
    assign sw      = {DATA_W{wr_en}} & be_full[DATA_W-1:0];

    if (DATA_W < CSR_MAX_W) begin : g_be_pad
        // Expansion bits beyond DATA_W have no consumer.
        logic unused_be_hi;
        assign unused_be_hi = ^be_full[CSR_MAX_W-1:DATA_W];
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        csr_bit_cell #(
            .MODE      (mode_of_bit(i, RO_X, W1C_X, W1S_X, W0C_X, RC_X, RS_X)),
            .RST_BIT   (RST_VAL[i]),
            .SHADOW_EN (SHADOW_EN != 0)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .sw          (sw[i]),
            .wr_bit      (wr_data[i]),
            .rd_en       (rd_en),
            .hw_we       (hw_we[i]),
            .hw_bit      (hw_data[i]),
            .commit      (commit),
            .live_q      (live_q[i]),
            .live_next   (live_next[i]),
            .shadow_next (shadow_next[i])
        );
    end

    // Both flags are computed from next-state values so they line up with
    // the edge that updates reg_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            chg_q     <= (live_next != live_q);
            pending_q <= (SHADOW_EN != 0) && (|((shadow_next ^ live_next) & RW_MASK));
        end
    end

    assign rd_data   = live_q;
    assign reg_o     = live_q;
    assign chg_o     = chg_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_csr_reg_param.sv
// -----------------------------------------------------------------------------
// tb_csr_reg_param
// Seven differently configured registers share one set of stimulus inputs.
// A word-level reference model, written straight from the access-mode rules,
// predicts live/shadow/chg/pending for each configuration every cycle;
// directed steps add literal expectations for the interesting corners.
// -----------------------------------------------------------------------------
module tb_csr_reg_param;

    localparam int NI = 7;

    typedef struct packed {
        logic [31:0] rst_val;
        logic [31:0] rw;
        logic [31:0] ro;
        logic [31:0] w1c;
        logic [31:0] w1s;
        logic [31:0] w0c;
        logic [31:0] rc;
        logic [31:0] rs;
        logic        sh;
    } cfg_t;

    //                   rst_val       rw            ro            w1c           w1s           w0c           rc            rs            sh
    localparam cfg_t [NI-1:0] CFG = {
        cfg_t'{32'h5A5A5A5A, 32'hC0000000, 32'h30000000, 32'h000000FF, 32'h0000FF00, 32'h000F0000, 32'h00F00000, 32'h0F000000, 1'b1}, // 6 mixed + shadow
        cfg_t'{32'h00000000, 32'hFFFFFFF0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h0000000F, 32'h00000000, 32'h00000000, 1'b0}, // 5 W0C
        cfg_t'{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0}, // 4 RO
        cfg_t'{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1}, // 3 shadow
        cfg_t'{32'h00000000, 32'hFFFFFF00, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h000000F0, 32'h0000000F, 1'b0}, // 2 RC/RS
        cfg_t'{32'h00000000, 32'hFFFFFF00, 32'h00000000, 32'h000000FF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0}, // 1 W1C
        cfg_t'{32'h000000A5, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0}  // 0 RW
    };

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] hw_we;
    logic [31:0] hw_data;
    logic        commit;

    logic [31:0]   reg_a  [NI];
    logic [31:0]   rd_a   [NI];
    logic [NI-1:0] pend_a;
    logic [NI-1:0] chg_a;

    logic [31:0] live_m   [NI];
    logic [31:0] shadow_m [NI];
    logic        chg_m    [NI];
    logic        pend_m   [NI];

    int checks;
    int failures;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        csr_reg_param #(
            .DATA_W    (32),
            .RST_VAL   (CFG[g].rst_val),
            .RW_MASK   (CFG[g].rw),
            .RO_MASK   (CFG[g].ro),
            .W1C_MASK  (CFG[g].w1c),
            .W1S_MASK  (CFG[g].w1s),
            .W0C_MASK  (CFG[g].w0c),
            .RC_MASK   (CFG[g].rc),
            .RS_MASK   (CFG[g].rs),
            .SHADOW_EN (CFG[g].sh ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en),
            .wr_be     (wr_be),
            .wr_data   (wr_data),
            .rd_en     (rd_en),
            .rd_data   (rd_a[g]),
            .hw_we     (hw_we),
            .hw_data   (hw_data),
            .commit    (commit),
            .reg_o     (reg_a[g]),
            .pending_o (pend_a[g]),
            .chg_o     (chg_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level reference: each mode's rule written as a whole-register
    // boolean expression, then merged through the masks.
    task automatic model_step(input int i);
        cfg_t        c;
        logic [31:0] sw, be_bits, live, sh, sh_n, hw_keep;
        logic [31:0] rw_n, ro_n, w1c_n, w1s_n, w0c_n, rc_n, rs_n, live_n;
        c    = CFG[i];
        live = live_m[i];
        sh   = shadow_m[i];
        if (rst) begin
            live_m[i]   = c.rst_val;
            shadow_m[i] = c.rst_val;
            chg_m[i]    = 1'b0;
            pend_m[i]   = 1'b0;
            return;
        end
        be_bits = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
        sw      = wr_en ? be_bits : 32'h0;
        hw_keep = (hw_we & hw_data) | (~hw_we & live);
        sh_n    = c.sh ? ((sw & wr_data) | (~sw & sh)) : sh;
        rw_n    = c.sh ? (commit ? sh_n : hw_keep)
                       : ((sw & wr_data) | (~sw & hw_keep));
        ro_n    = hw_keep;
        w1c_n   = (hw_we & hw_data) | (~hw_we & live & ~(sw & wr_data));
        w1s_n   = (hw_we & hw_data) | (~hw_we & (live | (sw & wr_data)));
        w0c_n   = (hw_we & hw_data) | (~hw_we & live & ~(sw & ~wr_data));
        rc_n    = (hw_we & hw_data) | (~hw_we & (rd_en ? 32'h0 : live));
        rs_n    = (hw_we & hw_data) | (~hw_we & (rd_en ? 32'hFFFFFFFF : live));
        live_n  = (c.rw & rw_n) | (c.ro & ro_n) | (c.w1c & w1c_n) | (c.w1s & w1s_n)
                | (c.w0c & w0c_n) | (c.rc & rc_n) | (c.rs & rs_n);
        live_m[i]   = live_n;
        shadow_m[i] = sh_n;
        chg_m[i]    = (live_n != live);
        pend_m[i]   = c.sh && (((sh_n ^ live_n) & c.rw) != 32'h0);
    endtask

    // Advance one clock with the current inputs and compare every instance.
    task automatic tick();
        for (int i = 0; i < NI; i++) model_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reg_o[%0d]", i),     reg_a[i],          live_m[i]);
            check($sformatf("rd_data[%0d]", i),   rd_a[i],           live_m[i]);
            check($sformatf("chg_o[%0d]", i),     32'(chg_a[i]),     32'(chg_m[i]));
            check($sformatf("pending_o[%0d]", i), 32'(pend_a[i]),    32'(pend_m[i]));
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_be = 4'h0; wr_data = 32'h0;
        rd_en = 1'b0; hw_we = 32'h0; hw_data = 32'h0; commit = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        @(negedge clk);

        // Reset state
        rst = 1'b1;
        tick();
        check("rst_reg_rw", reg_a[0], 32'h000000A5);
        check("rst_chg_rw", 32'(chg_a[0]), 32'h0);
        idle();

        // Byte-enabled RW write, then one-cycle change pulse
        wr_en = 1'b1; wr_be = 4'b0101; wr_data = 32'h12345678;
        tick();
        check("rw_be_write", reg_a[0], 32'h00340078);
        check("rw_chg_pulse", 32'(chg_a[0]), 32'h1);
        idle();
        tick();
        check("rw_chg_drop", 32'(chg_a[0]), 32'h0);

        // W1C against a simultaneous hardware write
        hw_we = 32'h000000FF; hw_data = 32'h0000000F;
        tick();
        idle();
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h00000003;
        hw_we = 32'h00000001; hw_data = 32'h00000001;
        tick();
        check("w1c_hw_wins", reg_a[1], 32'h0000000D);
        idle();

        // RC/RS read side effects
        hw_we = 32'h000000FF; hw_data = 32'h000000A0;
        tick();
        check("rcrs_load", reg_a[2], 32'h000000A0);
        idle();
        rd_en = 1'b1;
        #1;
        check("rcrs_rd_pre", rd_a[2], 32'h000000A0);
        tick();
        check("rcrs_after_rd", reg_a[2], 32'h0000000F);
        check("rcrs_rd_chg", 32'(chg_a[2]), 32'h1);
        #1;
        check("rcrs_rd2_pre", rd_a[2], 32'h0000000F);
        tick();
        check("rcrs_rd2_stable", reg_a[2], 32'h0000000F);
        check("rcrs_rd2_nochg", 32'(chg_a[2]), 32'h0);
        idle();

        // Shadow / commit
        commit = 1'b1;
        tick();
        check("sh_sync", reg_a[3], 32'h00000003);
        check("sh_sync_pend", 32'(pend_a[3]), 32'h0);
        idle();
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h0000CAFE;
        tick();
        check("sh_write_hold", reg_a[3], 32'h00000003);
        check("sh_write_pend", 32'(pend_a[3]), 32'h1);
        idle();
        commit = 1'b1;
        tick();
        check("sh_commit", reg_a[3], 32'h0000CAFE);
        check("sh_commit_pend", 32'(pend_a[3]), 32'h0);
        idle();
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h0000BEEF; commit = 1'b1;
        tick();
        check("sh_wr_commit", reg_a[3], 32'h0000BEEF);
        check("sh_wr_commit_pend", 32'(pend_a[3]), 32'h0);
        idle();

        // RO ignores software writes
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        tick();
        check("ro_ignore", reg_a[4], 32'h000000A0);
        check("ro_nochg", 32'(chg_a[4]), 32'h0);
        idle();

        // W0C
        hw_we = 32'hFFFFFFFF; hw_data = 32'h0000000F;
        tick();
        idle();
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h00000005;
        tick();
        check("w0c_clear", reg_a[5], 32'h00000005);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_be   = 4'($urandom);
            wr_data = $urandom;
            rd_en   = ($urandom_range(0, 2) == 0);
            hw_we   = $urandom & $urandom & $urandom;
            hw_data = $urandom;
            commit  = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();

        // Reset mid-operation overrides everything
        wr_en = 1'b1; wr_be = 4'hF; wr_data = 32'h0000FFFF; rd_en = 1'b1; commit = 1'b1;
        hw_we = 32'hFFFFFFFF; hw_data = 32'hFFFF0000;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midrst_reg[%0d]", i),  reg_a[i],       CFG[i].rst_val);
            check($sformatf("midrst_pend[%0d]", i), 32'(pend_a[i]), 32'h0);
            check($sformatf("midrst_chg[%0d]", i),  32'(chg_a[i]),  32'h0);
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
